wb_host_arbiter: RTL and testbench
==================================

// Module: wb_host_arbiter
// PURPOSE
//  Round-robin arbiter sharing one Ibex-style device port between NrHosts hosts
//  (core instr/data, debug). Sits between the hosts and the bus crossbar.
//  Supports one outstanding transaction; a response timeout returns an error.
// PARAMETERS
//  NrHosts       2   number of requesting hosts (>=2)
//  DataWidth     32  data bus width
//  AddressWidth  32  address bus width
//  TimeoutCycles 64  max cycles from grant to rvalid; 0 disables the timeout
// PORTS
//  clk_i          in   1               clock, all logic on rising edge
//  rst_i          in   1               async reset, active-high
//  host_req_i     in   NrHosts         per-host request; held high until gnt
//  host_gnt_o     out  NrHosts         per-host grant, one-hot or zero
//  host_addr_i    in   NrHosts*AW      per-host address
//  host_we_i      in   NrHosts         per-host write enable
//  host_be_i      in   NrHosts*DW/8    per-host byte enables
//  host_wdata_i   in   NrHosts*DW      per-host write data
//  host_rvalid_o  out  NrHosts         per-host response valid, one-hot or zero
//  host_rdata_o   out  DW              read data, shared by all hosts
//  host_err_o     out  1               response error, qualified by host_rvalid_o
//  dev_req_o      out  1               device request
//  dev_gnt_i      in   1               device grant
//  dev_addr_o     out  AW              muxed address
//  dev_we_o       out  1               muxed write enable
//  dev_be_o       out  DW/8            muxed byte enables
//  dev_wdata_o    out  DW              muxed write data
//  dev_rvalid_i   in   1               device response valid
//  dev_rdata_i    in   DW              device read data
//  dev_err_i      in   1               device error
// BEHAVIOUR
//  Reset: state=IDLE, last=NrHosts-1, sel=0, timer=0. All outputs 0.
//  States:
//   IDLE: sel = first requesting host after last, searched round-robin.
//     dev_req_o = |host_req_i. dev_* fields muxed from sel.
//     host_gnt_o[sel] = dev_gnt_i, combinational.
//     If dev_gnt_i: owner<=sel, timer<=0, go to RESP.
//     If req without gnt: hold sel, go to REQ.
//   REQ: drive the held sel; the choice must not change.
//     On dev_gnt_i: owner<=sel, go to RESP.
//     If host_req_i[sel] drops (protocol violation): go to IDLE, no grant.
//   RESP: dev_req_o=0, host_gnt_o=0. host_rdata_o=dev_rdata_i, combinational.
//     On dev_rvalid_i: host_rvalid_o[owner]=1, host_err_o=dev_err_i;
//       last<=owner, go to IDLE. New arbitration starts the next cycle.
//     Otherwise timer++. When timer==TimeoutCycles-1 with no rvalid (and
//       TimeoutCycles!=0): host_rvalid_o[owner]=1, host_err_o=1, rdata=0,
//       last<=owner, go to IDLE.
//  Minimum cycle: req+gnt in cycle N, rvalid at earliest N+1, next grant N+2.
//  dev_rvalid_i outside RESP (late response after timeout) is dropped and never
//   forwarded. This is a known limit: a late rvalid during the next RESP is
//   misattributed. Size TimeoutCycles above the slowest device.
//  Grant and rvalid of the same host never occur in the same cycle.
//  A sole requester is granted back-to-back with no fairness penalty.
//  Timer width is $clog2(TimeoutCycles+1) and saturates; it never wraps.
//  rst_i mid-transaction: return to IDLE immediately and drop any in-flight
//   response. Hosts must also be reset.
// TESTING
//  1. Host0 read alone, dev gnt same cycle, rvalid+rdata=0xDEADBEEF 2 cycles
//     later -> gnt[0] in cycle 0; rvalid[0]=1 with rdata 0xDEADBEEF, err=0.
//  2. Both hosts req continuously, dev always grants, rvalid 1 cycle after gnt
//     -> grants alternate 0,1,0,1 starting at host0; each granted every 4 cycles.
//  3. Host1 req, dev_gnt_i held low 3 cycles, host0 raises req meanwhile
//     -> dev_addr_o stays host1's; gnt[1] when dev_gnt_i rises.
//  4. Host0 write, addr 0x100, be=4'b0011, no rvalid for 64 cycles
//     -> rvalid[0]=1, err=1 exactly 64 cycles after gnt; late rvalid ignored.
//  5. Device returns dev_err_i=1 on rvalid -> host_err_o=1 on the owner only;
//     the other host sees rvalid=0.
//  6. Assert rst_i while in RESP -> all outputs 0 immediately; a post-reset
//     request is granted to host0.

Source files
------------

// File: rtl/wb_host_arbiter.sv
// rtl/wb_host_arbiter.sv - round-robin arbiter sharing one device port between several hosts
// One transaction in flight at a time; a silent device is answered with an error after a timeout.
module wb_host_arbiter #(
    parameter int NrHosts       = 2,
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int TimeoutCycles = 64
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NrHosts-1:0]                host_req_i,
    output logic [NrHosts-1:0]                host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                host_we_i,
    input  logic [NrHosts*DataWidth/8-1:0]    host_be_i,
    input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                host_rvalid_o,
    output logic [DataWidth-1:0]              host_rdata_o,
    output logic                              host_err_o,
    output logic                              dev_req_o,
    input  logic                              dev_gnt_i,
    output logic [AddressWidth-1:0]           dev_addr_o,
    output logic                              dev_we_o,
    output logic [DataWidth/8-1:0]            dev_be_o,
    output logic [DataWidth-1:0]              dev_wdata_o,
    input  logic                              dev_rvalid_i,
    input  logic [DataWidth-1:0]              dev_rdata_i,
    input  logic                              dev_err_i
);

    localparam int BeWidth = DataWidth / 8;
    localparam int IdxW    = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int TimerW  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [IdxW-1:0]   LastInit  = IdxW'(NrHosts - 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam logic [TimerW-1:0] TimerMax  = '1;
    localparam bit                TimeoutEn = (TimeoutCycles != 0);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_e;

    state_e              state_q;
    logic [IdxW-1:0]     last_q;
    logic [IdxW-1:0]     sel_q;
    logic [IdxW-1:0]     owner_q;
    logic [TimerW-1:0]   timer_q;

    logic [IdxW-1:0]     arb_sel;
    logic [IdxW-1:0]     cur_sel;
    logic                any_req;
    logic                held_req;
    logic                timeout_hit;
    logic [AddressWidth-1:0] mux_addr;
    logic                mux_we;
    logic [BeWidth-1:0]  mux_be;
    logic [DataWidth-1:0] mux_wdata;

    function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NrHosts) sum = sum - NrHosts;
        return IdxW'(sum);
    endfunction

    // Scan from the farthest candidate inward so the nearest requester after last_q wins.
    always_comb begin
        arb_sel = '0;
        for (int i = NrHosts; i >= 1; i--) begin
            if (host_req_i[rr_idx(last_q, i)]) arb_sel = rr_idx(last_q, i);
        end
    end

    assign any_req     = |host_req_i;
    assign held_req    = host_req_i[sel_q];
    assign cur_sel     = (state_q == REQ) ? sel_q : arb_sel;
    assign timeout_hit = TimeoutEn && (state_q == RESP) && !dev_rvalid_i && (timer_q == TimerLast);

    always_comb begin
        mux_addr  = '0;
        mux_we    = 1'b0;
        mux_be    = '0;
        mux_wdata = '0;
        for (int h = 0; h < NrHosts; h++) begin
            if (cur_sel == IdxW'(h)) begin
                mux_addr  = host_addr_i[h*AddressWidth +: AddressWidth];
                mux_we    = host_we_i[h];
                mux_be    = host_be_i[h*BeWidth +: BeWidth];
                mux_wdata = host_wdata_i[h*DataWidth +: DataWidth];
            end
        end
    end

    // Outputs are forced low while reset is held so nothing leaks from requesting hosts.
    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_rdata_o  = '0;
        host_err_o    = 1'b0;
        dev_req_o     = 1'b0;
        dev_addr_o    = '0;
        dev_we_o      = 1'b0;
        dev_be_o      = '0;
        dev_wdata_o   = '0;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    dev_req_o = any_req;
                    if (any_req) host_gnt_o[arb_sel] = dev_gnt_i;
                end
                REQ: begin
                    dev_req_o = held_req;
                    if (held_req) host_gnt_o[sel_q] = dev_gnt_i;
                end
                RESP: begin
                    host_rdata_o = timeout_hit ? '0 : dev_rdata_i;
                    if (dev_rvalid_i) begin
                        host_rvalid_o[owner_q] = 1'b1;
                        host_err_o             = dev_err_i;
                    end else if (timeout_hit) begin
                        host_rvalid_o[owner_q] = 1'b1;
                        host_err_o             = 1'b1;
                    end
                end
                default: ;
            endcase
            if (dev_req_o) begin
                dev_addr_o  = mux_addr;
                dev_we_o    = mux_we;
                dev_be_o    = mux_be;
                dev_wdata_o = mux_wdata;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= LastInit;
            sel_q   <= '0;
            owner_q <= '0;
            timer_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        sel_q <= arb_sel;
                        if (dev_gnt_i) begin
                            owner_q <= arb_sel;
                            timer_q <= '0;
                            state_q <= RESP;
                        end else begin
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    // A host withdrawing before its grant is abandoned without a grant.
                    if (!held_req) begin
                        state_q <= IDLE;
                    end else if (dev_gnt_i) begin
                        owner_q <= sel_q;
                        timer_q <= '0;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (dev_rvalid_i || timeout_hit) begin
                        last_q  <= owner_q;
                        state_q <= IDLE;
                    end else if (timer_q != TimerMax) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_host_arbiter.sv
// tb/tb_wb_host_arbiter.sv - self-checking bench for wb_host_arbiter
module tb_wb_host_arbiter;

    localparam int NH = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [NH-1:0]   host_req_i;
    logic [NH-1:0]   host_gnt_o;
    logic [NH*AW-1:0] host_addr_i;
    logic [NH-1:0]   host_we_i;
    logic [NH*DW/8-1:0] host_be_i;
    logic [NH*DW-1:0] host_wdata_i;
    logic [NH-1:0]   host_rvalid_o;
    logic [DW-1:0]   host_rdata_o;
    logic            host_err_o;
    logic            dev_req_o;
    logic            dev_gnt_i;
    logic [AW-1:0]   dev_addr_o;
    logic            dev_we_o;
    logic [DW/8-1:0] dev_be_o;
    logic [DW-1:0]   dev_wdata_o;
    logic            dev_rvalid_i;
    logic [DW-1:0]   dev_rdata_i;
    logic            dev_err_i;

    logic [31:0] ha [NH];
    logic        hw [NH];
    logic [3:0]  hb [NH];
    logic [31:0] hd [NH];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        host_addr_i  = {ha[1], ha[0]};
        host_we_i    = {hw[1], hw[0]};
        host_be_i    = {hb[1], hb[0]};
        host_wdata_i = {hd[1], hd[0]};
    end

    wb_host_arbiter #(
        .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(host_req_i), .host_gnt_o(host_gnt_o),
        .host_addr_i(host_addr_i), .host_we_i(host_we_i),
        .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
        .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
        .host_err_o(host_err_o),
        .dev_req_o(dev_req_o), .dev_gnt_i(dev_gnt_i),
        .dev_addr_o(dev_addr_o), .dev_we_o(dev_we_o),
        .dev_be_o(dev_be_o), .dev_wdata_o(dev_wdata_o),
        .dev_rvalid_i(dev_rvalid_i), .dev_rdata_i(dev_rdata_i),
        .dev_err_i(dev_err_i)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        host_req_i   = '0;
        dev_gnt_i    = 1'b0;
        dev_rvalid_i = 1'b0;
        dev_rdata_i  = '0;
        dev_err_i    = 1'b0;
        for (int h = 0; h < NH; h++) begin
            ha[h] = 32'h1000 * (h + 1);
            hw[h] = 1'b0;
            hb[h] = 4'hF;
            hd[h] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic        rst;
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic        err;
        logic [31:0] rdata;
        logic [1:0]  e_gnt;
        logic [1:0]  e_rv;
        logic        e_err;
        logic        e_dreq;
        logic [31:0] e_rdata;
        logic [31:0] e_addr;
    } vec_t;

    function automatic vec_t mk(logic r, logic [1:0] q, logic g, logic v, logic e, logic [31:0] d,
                                logic [1:0] eg, logic [1:0] ev, logic ee, logic edq,
                                logic [31:0] ed, logic [31:0] ea);
        vec_t t;
        t = '{r, q, g, v, e, d, eg, ev, ee, edq, ed, ea};
        return t;
    endfunction

    // Reference model state for the randomized phase.
    int m_owner, m_lock, m_last, m_wait;
    int hs [NH];

    initial begin : main
        vec_t vecs [14];
        rst = 1'b1;
        clear_inputs();
        #1;
        chk("reset_gnt", host_gnt_o, 0);
        chk("reset_rvalid", host_rvalid_o, 0);
        chk("reset_dev_req", dev_req_o, 0);
        chk("reset_rdata", host_rdata_o, 0);
        chk("reset_err", host_err_o, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single read, alternation of two hosts, device error.
        vecs[0]  = mk(0, 2'b01, 1, 0, 0, 32'h0,        2'b01, 2'b00, 0, 1, 32'h0,        32'h1000);
        vecs[1]  = mk(0, 2'b00, 0, 0, 0, 32'h0,        2'b00, 2'b00, 0, 0, 32'h0,        32'h0);
        vecs[2]  = mk(0, 2'b00, 0, 1, 0, 32'hDEADBEEF, 2'b00, 2'b01, 0, 0, 32'hDEADBEEF, 32'h0);
        vecs[3]  = mk(1, 2'b11, 1, 1, 1, 32'h1234,     2'b00, 2'b00, 0, 0, 32'h0,        32'h0);
        vecs[4]  = mk(0, 2'b11, 1, 0, 0, 32'h0,        2'b01, 2'b00, 0, 1, 32'h0,        32'h1000);
        vecs[5]  = mk(0, 2'b11, 1, 1, 0, 32'hA5A50001, 2'b00, 2'b01, 0, 0, 32'hA5A50001, 32'h0);
        vecs[6]  = mk(0, 2'b11, 1, 0, 0, 32'h0,        2'b10, 2'b00, 0, 1, 32'h0,        32'h2000);
        vecs[7]  = mk(0, 2'b11, 1, 1, 0, 32'hA5A50002, 2'b00, 2'b10, 0, 0, 32'hA5A50002, 32'h0);
        vecs[8]  = mk(0, 2'b11, 1, 0, 0, 32'h0,        2'b01, 2'b00, 0, 1, 32'h0,        32'h1000);
        vecs[9]  = mk(0, 2'b11, 1, 1, 0, 32'h3,        2'b00, 2'b01, 0, 0, 32'h3,        32'h0);
        vecs[10] = mk(0, 2'b11, 1, 0, 0, 32'h0,        2'b10, 2'b00, 0, 1, 32'h0,        32'h2000);
        vecs[11] = mk(0, 2'b11, 1, 1, 0, 32'h4,        2'b00, 2'b10, 0, 0, 32'h4,        32'h0);
        vecs[12] = mk(0, 2'b01, 1, 0, 0, 32'h0,        2'b01, 2'b00, 0, 1, 32'h0,        32'h1000);
        vecs[13] = mk(0, 2'b00, 0, 1, 1, 32'h55,       2'b00, 2'b01, 1, 0, 32'h55,       32'h0);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            rst          = vecs[i].rst;
            host_req_i   = vecs[i].req;
            dev_gnt_i    = vecs[i].gnt;
            dev_rvalid_i = vecs[i].rv;
            dev_err_i    = vecs[i].err;
            dev_rdata_i  = vecs[i].rdata;
            #1;
            chk($sformatf("vec%0d_gnt", i), host_gnt_o, vecs[i].e_gnt);
            chk($sformatf("vec%0d_rvalid", i), host_rvalid_o, vecs[i].e_rv);
            chk($sformatf("vec%0d_dev_req", i), dev_req_o, vecs[i].e_dreq);
            if (vecs[i].e_rv != 0 || vecs[i].rst) begin
                chk($sformatf("vec%0d_err", i), host_err_o, vecs[i].e_err);
                chk($sformatf("vec%0d_rdata", i), host_rdata_o, vecs[i].e_rdata);
            end
            if (vecs[i].e_dreq) chk($sformatf("vec%0d_addr", i), dev_addr_o, vecs[i].e_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();

        // Choice held while the device stalls, even when another host joins.
        do_reset();
        @(negedge clk); host_req_i = 2'b10;
        #1; chk("t3_addr_first", dev_addr_o, 32'h2000); chk("t3_no_gnt", host_gnt_o, 0);
        chk("t3_dev_req", dev_req_o, 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); host_req_i = 2'b11;
            #1; chk("t3_addr_hold", dev_addr_o, 32'h2000); chk("t3_hold_gnt", host_gnt_o, 0);
        end
        @(negedge clk); dev_gnt_i = 1'b1;
        #1; chk("t3_gnt1", host_gnt_o, 2'b10); chk("t3_addr_at_gnt", dev_addr_o, 32'h2000);
        @(negedge clk); host_req_i = 2'b01; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b1; dev_rdata_i = 32'h77;
        #1; chk("t3_rvalid1", host_rvalid_o, 2'b10); chk("t3_rdata", host_rdata_o, 32'h77);
        @(negedge clk); dev_rvalid_i = 1'b0; dev_gnt_i = 1'b1;
        #1; chk("t3_next_gnt0", host_gnt_o, 2'b01);
        @(negedge clk); host_req_i = 2'b00; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b1;
        #1; chk("t3_rvalid0", host_rvalid_o, 2'b01);
        @(negedge clk); dev_rvalid_i = 1'b0;

        // Timeout on a write, then a late response that must be dropped.
        do_reset();
        ha[0] = 32'h100; hw[0] = 1'b1; hb[0] = 4'b0011; hd[0] = 32'hCAFE0001;
        @(negedge clk); host_req_i = 2'b01; dev_gnt_i = 1'b1;
        #1; chk("t4_gnt", host_gnt_o, 2'b01); chk("t4_we", dev_we_o, 1);
        chk("t4_be", dev_be_o, 4'b0011); chk("t4_addr", dev_addr_o, 32'h100);
        chk("t4_wdata", dev_wdata_o, 32'hCAFE0001);
        for (int k = 1; k < TO; k++) begin
            @(negedge clk); host_req_i = 2'b00; dev_gnt_i = 1'b0; dev_rdata_i = 32'hBAD0BAD0;
            #1; chk($sformatf("t4_wait%0d", k), host_rvalid_o, 0);
        end
        @(negedge clk);
        #1; chk("t4_to_rvalid", host_rvalid_o, 2'b01); chk("t4_to_err", host_err_o, 1);
        chk("t4_to_rdata", host_rdata_o, 0);
        @(negedge clk); dev_rvalid_i = 1'b1;
        #1; chk("t4_late_dropped", host_rvalid_o, 0);
        @(negedge clk); dev_rvalid_i = 1'b0; host_req_i = 2'b10; dev_gnt_i = 1'b1;
        #1; chk("t4_after_gnt", host_gnt_o, 2'b10);
        @(negedge clk); host_req_i = 2'b00; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b1;
        #1; chk("t4_after_rvalid", host_rvalid_o, 2'b10);
        @(negedge clk); dev_rvalid_i = 1'b0;

        // Reset during a response restores round-robin start and drops the response.
        do_reset();
        @(negedge clk); host_req_i = 2'b01; dev_gnt_i = 1'b1;
        @(negedge clk); host_req_i = 2'b00; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b1;
        #1; chk("t6_first_rvalid", host_rvalid_o, 2'b01);
        @(negedge clk); dev_rvalid_i = 1'b0; host_req_i = 2'b10; dev_gnt_i = 1'b1;
        #1; chk("t6_gnt1", host_gnt_o, 2'b10);
        @(negedge clk); host_req_i = 2'b00; dev_gnt_i = 1'b0;
        dev_rvalid_i = 1'b1; dev_err_i = 1'b1; dev_rdata_i = 32'h99; rst = 1'b1;
        #1; chk("t6_rst_rvalid", host_rvalid_o, 0); chk("t6_rst_err", host_err_o, 0);
        chk("t6_rst_rdata", host_rdata_o, 0); chk("t6_rst_gnt", host_gnt_o, 0);
        chk("t6_rst_dev_req", dev_req_o, 0);
        @(negedge clk); rst = 1'b0; dev_rvalid_i = 1'b0; dev_err_i = 1'b0;
        host_req_i = 2'b11; dev_gnt_i = 1'b1;
        #1; chk("t6_post_gnt0", host_gnt_o, 2'b01);
        @(negedge clk); host_req_i = 2'b00; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b1;
        #1; chk("t6_post_rvalid", host_rvalid_o, 2'b01);
        @(negedge clk); dev_rvalid_i = 1'b0;

        // Randomized traffic against a transaction-level model.
        do_reset();
        m_owner = -1; m_lock = -1; m_last = NH - 1; m_wait = 0;
        for (int h = 0; h < NH; h++) hs[h] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [1:0]  e_gnt, e_rv;
            logic        e_err, e_dreq;
            logic [31:0] e_rdata;
            int          pick;
            @(negedge clk);
            for (int h = 0; h < NH; h++) begin
                if (hs[h] == 0 && $urandom_range(0, 2) == 0) begin
                    hs[h] = 1;
                    ha[h] = $urandom; hw[h] = 1'($urandom_range(0, 1));
                    hb[h] = 4'($urandom); hd[h] = $urandom;
                end else if (hs[h] == 1 && $urandom_range(0, 49) == 0) begin
                    hs[h] = 0;
                end
                host_req_i[h] = (hs[h] == 1);
            end
            dev_gnt_i    = 1'($urandom_range(0, 1));
            dev_rvalid_i = ((cyc % 400) < 90) ? 1'b0 : ($urandom_range(0, 2) == 0);
            dev_err_i    = 1'($urandom_range(0, 1));
            dev_rdata_i  = $urandom;
            #1;
            e_gnt = '0; e_rv = '0; e_err = 1'b0; e_dreq = 1'b0; e_rdata = '0; pick = -1;
            if (m_owner >= 0) begin
                e_rdata = dev_rdata_i;
                if (dev_rvalid_i) begin
                    e_rv[m_owner] = 1'b1; e_err = dev_err_i;
                end else if (m_wait == TO - 1) begin
                    e_rv[m_owner] = 1'b1; e_err = 1'b1; e_rdata = '0;
                end
            end else if (m_lock >= 0) begin
                if (host_req_i[m_lock]) pick = m_lock;
            end else begin
                for (int i = NH; i >= 1; i--)
                    if (host_req_i[(m_last + i) % NH]) pick = (m_last + i) % NH;
            end
            if (pick >= 0) begin
                e_dreq = 1'b1; e_gnt[pick] = dev_gnt_i;
            end
            chk("rnd_gnt", host_gnt_o, e_gnt);
            chk("rnd_rvalid", host_rvalid_o, e_rv);
            chk("rnd_dev_req", dev_req_o, e_dreq);
            if (m_owner >= 0) chk("rnd_rdata", host_rdata_o, e_rdata);
            if (e_rv != 0) chk("rnd_err", host_err_o, e_err);
            if (pick >= 0) begin
                chk("rnd_addr", dev_addr_o, ha[pick]);
                chk("rnd_fields", {dev_we_o, dev_be_o, dev_wdata_o}, {hw[pick], hb[pick], hd[pick]});
            end
            if (m_owner >= 0) begin
                if (e_rv != 0) begin m_last = m_owner; m_owner = -1; end
                else m_wait++;
            end else if (m_lock >= 0) begin
                if (!host_req_i[m_lock]) m_lock = -1;
                else if (dev_gnt_i) begin m_owner = m_lock; m_lock = -1; m_wait = 0; end
            end else if (pick >= 0) begin
                if (dev_gnt_i) begin m_owner = pick; m_wait = 0; end
                else m_lock = pick;
            end
            for (int h = 0; h < NH; h++) begin
                if (e_gnt[h]) hs[h] = 2;
                if (e_rv[h]) hs[h] = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
